// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception codes, reset/vector addresses, memory map
// and the bundle type that travels between fetch and decode.
package cpu_defs;

    localparam logic [31:0] CPU_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] CPU_IM_BASE  = 32'h0000_3000;
    localparam int unsigned CPU_IM_WORDS = 32'd4096;
    localparam logic [31:0] CPU_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXC_CODE_NONE = 5'd0;
    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CODE_RI   = 5'd10;
    localparam logic [4:0] EXC_CODE_OV   = 5'd12;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } d_stage_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        logic [15:0] res;
        if (val == STALL_CNT_MAX) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational address-error detector: flags misaligned word accesses and
// addresses outside [IM_BASE, IM_BASE + 4*IM_WORDS).
module fetch_addr_chk
    import cpu_defs::*;
#(
    parameter logic [31:0] IM_BASE  = CPU_IM_BASE,
    parameter int unsigned IM_WORDS = CPU_IM_WORDS
) (
    input  logic [31:0] pc,
    output logic        adel
);

    // Upper bound kept in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    logic misaligned_s;
    logic below_s;
    logic above_s;

    // Classify the fetch address.
    always_comb begin
        misaligned_s = (pc[1:0] != 2'b00);
        below_s      = (pc < IM_BASE);
        above_s      = ({1'b0, pc} >= IM_LIMIT);
        adel         = misaligned_s | below_s | above_s;
    end

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register with stall, flush and exception-entry
// control, fetch address-error tagging and a saturating stall counter.
module fd_pipe_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_RESET = CPU_PC_RESET,
    parameter logic [31:0] IM_BASE  = CPU_IM_BASE,
    parameter int unsigned IM_WORDS = CPU_IM_WORDS,
    parameter logic [31:0] EXC_VEC  = CPU_EXC_VEC,
    parameter logic [4:0]  EXC_ADEL = EXC_CODE_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        req,
    input  logic [31:0] f_instr,
    input  logic [31:0] f_pc,
    input  logic        f_bd,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [4:0]  d_exc,
    output logic        d_bd,
    output logic        d_valid,
    output logic [15:0] stall_cnt
);

    d_stage_t    d_stage_r;
    d_stage_t    d_stage_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] stall_cnt_s;
    logic        adel_s;

    fetch_addr_chk #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_fetch_addr_chk (
        .pc   (f_pc),
        .adel (adel_s)
    );

    // Next-state selection: req beats stall, stall beats flush, flush beats load.
    always_comb begin
        d_stage_s   = d_stage_r;
        stall_cnt_s = stall_cnt_r;
        if (req) begin
            d_stage_s.instr = NOP_WORD;
            d_stage_s.pc    = EXC_VEC;
            d_stage_s.exc   = EXC_CODE_NONE;
            d_stage_s.bd    = 1'b0;
            d_stage_s.valid = 1'b0;
        end else if (!en) begin
            stall_cnt_s = sat_inc16(stall_cnt_r);
        end else if (flush) begin
            d_stage_s.instr = NOP_WORD;
            d_stage_s.pc    = f_pc;
            d_stage_s.exc   = EXC_CODE_NONE;
            d_stage_s.bd    = 1'b0;
            d_stage_s.valid = 1'b0;
        end else begin
            d_stage_s.pc    = f_pc;
            d_stage_s.bd    = f_bd;
            d_stage_s.valid = 1'b1;
            if (adel_s) begin
                // The fetched word is meaningless; decode sees a tagged nop.
                d_stage_s.instr = NOP_WORD;
                d_stage_s.exc   = EXC_ADEL;
            end else begin
                d_stage_s.instr = f_instr;
                d_stage_s.exc   = EXC_CODE_NONE;
            end
        end
    end

    // Stage register and stall counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_stage_r.instr <= NOP_WORD;
            d_stage_r.pc    <= PC_RESET;
            d_stage_r.exc   <= EXC_CODE_NONE;
            d_stage_r.bd    <= 1'b0;
            d_stage_r.valid <= 1'b0;
            stall_cnt_r     <= 16'd0;
        end else begin
            d_stage_r   <= d_stage_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign d_instr   = d_stage_r.instr;
    assign d_pc      = d_stage_r.pc;
    assign d_exc     = d_stage_r.exc;
    assign d_bd      = d_stage_r.bd;
    assign d_valid   = d_stage_r.valid;
    assign stall_cnt = stall_cnt_r;

endmodule
